// File: rtl/mult_hilo_ctrl.sv
// Execute-stage controller for the serial multiplier and the HI/LO registers.
// Latches one multiply per issue, starts the multiplier, waits for its sticky
// done flag to clear and rise again, then writes the 64-bit product to HI/LO.
// Also serves MFHI/MFLO/MTHI/MTLO and the pipeline stall interlock.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   issue_valid/_signed/_a/_b multiply issue from EX
//   flush                    squash the in-flight multiply
//   mfhi_req, mflo_req       HI/LO read requests (rd_data, combinational)
//   mthi_valid, mtlo_valid   HI/LO writes of mt_data (applied in IDLE)
//   mul_prod, mul_done       multiplier result and sticky done level
//   mul_start/_signed/_a/_b  registered multiplier request
//   hi, lo                   architectural HI/LO
//   stall, busy              interlock and in-flight indication
//   err_timeout              sticky multiplier timeout flag
module mult_hilo_ctrl #(
  parameter int unsigned TIMEOUT = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic        issue_signed,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic        flush,
  input  logic        mfhi_req,
  input  logic        mflo_req,
  input  logic        mthi_valid,
  input  logic        mtlo_valid,
  input  logic [31:0] mt_data,
  input  logic [63:0] mul_prod,
  input  logic        mul_done,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_CLR,
    WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic               mul_start_q, mul_start_d;
  logic               mul_signed_q, mul_signed_d;
  logic               discard_q, discard_d;
  logic               err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Next-state and register updates
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    mul_start_d   = mul_start_q;
    mul_signed_d  = mul_signed_q;
    discard_d     = discard_q;
    err_timeout_d = err_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        // MT writes land even alongside an issue; the product overwrites later
        if (mthi_valid) hi_d = mt_data;
        if (mtlo_valid) lo_d = mt_data;
        if (issue_valid && !flush) begin
          mul_a_d      = issue_a;
          mul_b_d      = issue_b;
          mul_signed_d = issue_signed;
          discard_d    = 1'b0;
          state_d      = START;
        end
      end

      START: begin
        mul_start_d = 1'b1;
        cnt_d       = '0;
        if (flush) discard_d = 1'b1;
        state_d     = WAIT_CLR;
      end

      // Hold start until the previous op's sticky done has dropped
      WAIT_CLR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush) discard_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          err_timeout_d = 1'b1;
          mul_start_d   = 1'b0;
          state_d       = IDLE;
        end else if (!mul_done) begin
          mul_start_d = 1'b0;
          state_d     = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush) discard_d = 1'b1;
        if (mul_done) begin
          // A flush arriving on the capture cycle still squashes the result
          if (!(discard_q || flush)) begin
            hi_d = mul_prod[63:32];
            lo_d = mul_prod[31:0];
          end
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout_d = 1'b1;
          mul_start_d   = 1'b0;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_start_q   <= 1'b0;
      mul_signed_q  <= 1'b0;
      discard_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_start_q   <= mul_start_d;
      mul_signed_q  <= mul_signed_d;
      discard_q     <= discard_d;
      err_timeout_q <= err_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // Read mux: MFHI wins, no bypass of same-cycle MT writes
  always_comb begin
    rd_data = '0;
    if (mfhi_req)      rd_data = hi_q;
    else if (mflo_req) rd_data = lo_q;
  end

  assign busy        = (state_q != IDLE);
  assign stall       = busy & (issue_valid | mfhi_req | mflo_req | mthi_valid | mtlo_valid);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_start   = mul_start_q;
  assign mul_signed  = mul_signed_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- Execute-stage controller between issue logic and the serial multiplier.
- Accepts one multiply per issue and launches it on the multiplier's start/operand interface.
- Tracks the multiplier's sticky done flag and writes the 64-bit product into architectural HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO and generates the pipeline stall interlock while a multiply is in flight.

Parameters:
TIMEOUT, 96, maximum cycles spent in WAIT_CLR+WAIT_DONE before aborting; counter width $clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  multiply instruction present in EX
- issue_signed  in  1  1 = signed multiply
- issue_a  in  32  operand A
- issue_b  in  32  operand B
- flush  in  1  squash the in-flight multiply (result discarded)
- mfhi_req  in  1  read HI
- mflo_req  in  1  read LO
- mthi_valid  in  1  write mt_data to HI
- mtlo_valid  in  1  write mt_data to LO
- mt_data  in  32  MTHI/MTLO data
- mul_prod  in  64  multiplier product
- mul_done  in  1  multiplier done; level, sticky until next start accepted
- mul_start  out  1  start request to multiplier
- mul_signed  out  1  registered issue_signed
- mul_a  out  32  registered operand A
- mul_b  out  32  registered operand B
- hi  out  32  HI register
- lo  out  32  LO register
- rd_data  out  32  combinational read data
- stall  out  1  hold upstream pipeline
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate):
  - state=IDLE
  - hi, lo, mul_a, mul_b = 0
  - mul_start, mul_signed, discard, err_timeout = 0
  - counter = 0
  - Reset mid-operation abandons the op; no HI/LO write.
- States: IDLE, START, WAIT_CLR, WAIT_DONE.
- IDLE:
  - issue_valid=1 → latch issue_a/b/signed into mul_a/mul_b/mul_signed, clear discard, go to START.
  - MTHI/MTLO write HI/LO at the clock edge; applied even when issue_valid is high in the same cycle (the later product overwrites).
- START:
  - mul_start=1; counter cleared; go to WAIT_CLR.
- WAIT_CLR:
  - mul_start stays 1 while mul_done=1. The multiplier's stale done from the previous op must drop first.
  - First cycle with mul_done=0 → mul_start=0, go to WAIT_DONE.
- WAIT_DONE:
  - mul_done=1 → if discard=0, {hi,lo} <= mul_prod (hi = mul_prod[63:32]); then go to IDLE.
  - HI/LO are visible to reads from the cycle after the capture edge.
- Timeout:
  - Counter increments each cycle in WAIT_CLR/WAIT_DONE.
  - When counter reaches TIMEOUT-1 with no completion: err_timeout<=1 (held until rst), mul_start<=0, go to IDLE, no HI/LO write.
- Flush:
  - In START/WAIT_*: sets discard; the FSM still runs to completion or timeout, so the multiplier is never left mid-op.
  - In IDLE: flush has no effect, and a same-cycle issue_valid is ignored (flush wins).
- Stall:
  - stall = busy & (issue_valid | mfhi_req | mflo_req | mthi_valid | mtlo_valid).
  - MT writes and new issues while busy are held by the pipeline, never dropped by this block.
- Reads:
  - rd_data = mfhi_req ? hi : (mflo_req ? lo : 0). MFHI has priority if both are asserted.
  - A read in the same cycle as an MT write returns the old value (no bypass).
- Latency: issue → HI/LO valid = 3 cycles + multiplier latency + done-clear cycles.
- mul_prod is sampled only at the capture edge; it is ignored at all other times.

Test Plan:
- Unsigned a=3, b=5, multiplier done after 6 cycles → stall released with the write; hi=0, lo=15; next-cycle MFLO rd_data=15.
- Signed a=0xFFFFFFFE, b=3, model returns 0xFFFFFFFFFFFFFFFA → hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MFHI asserted one cycle after issue → stall=1 every cycle until the capture edge; next cycle stall=0 and rd_data=new hi.
- IDLE: MTHI 0xDEADBEEF, next-cycle MFHI → rd_data=0xDEADBEEF; MTHI+MFHI in the same cycle → old hi returned.
- hi=lo=0x11111111, issue 4×4, flush in WAIT_DONE → FSM completes, hi/lo stay 0x11111111, busy drops when mul_done rises.
- mul_done stuck at 1 after issue → mul_start held; after 96 cycles err_timeout=1, busy=0, hi/lo unchanged. rst asserted mid-WAIT_DONE → all outputs 0 immediately.
